store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 184 ++++++++++++++++++
 tb/tb_store_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the MEM stage and data memory.
// Stores are queued with their word address, byte mask and lane-aligned data,
// then drained one per memAck in push order. Loads that hit a pending entry
// stall until the entry drains.
// Optional feature: define STB_FORWARD_EN to forward a full-word (byteEnable ==
// 4'b1111) youngest matching entry straight to the load instead of stalling.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic        stallM,
  output logic        fwdValid,
  output logic [31:0] fwdData,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memBE,
  input  logic        memAck,
  output logic        empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  // Queue pointers and occupancy
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  // Entry storage (contents are don't-care while the entry is invalid)
  logic [29:0] addr_q [DEPTH];
  logic [29:0] addr_d [DEPTH];
  logic [3:0]  be_q   [DEPTH];
  logic [3:0]  be_d   [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];

  logic        full;
  logic        store_req;
  logic        push;
  logic        pop;
  logic [4:0]  shamt;
  logic [31:0] shifted_data;
  logic        match;
  logic        load_match;
  logic        fwd_hit;
  logic [PtrW-1:0] scan_idx;

  // Low address bits only select lanes, which byteEnable already encodes
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^ALUResultM[1:0];

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign store_req = MemWriteM && (byteEnable != 4'b0000);
  assign push      = store_req && !full;
  assign pop       = !empty && memAck;

  // Lane shift from the lowest set bit of the byte mask
  always_comb begin
    shamt = 5'd0;
    casez (byteEnable)
      4'b???1: shamt = 5'd0;
      4'b??10: shamt = 5'd8;
      4'b?100: shamt = 5'd16;
      4'b1000: shamt = 5'd24;
      default: shamt = 5'd0;
    endcase
  end

  assign shifted_data = WriteDataM << shamt;

  // Address match scan, oldest to youngest so the last hit is the youngest
`ifdef STB_FORWARD_EN
  logic [3:0]  match_be;
  logic [31:0] match_data;

  always_comb begin
    match      = 1'b0;
    match_be   = 4'b0000;
    match_data = 32'h0;
    scan_idx   = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PtrW'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == ALUResultM[31:2])) begin
        match      = 1'b1;
        match_be   = be_q[scan_idx];
        match_data = data_q[scan_idx];
      end
    end
  end

  assign load_match = MemReadM && match;
  assign fwd_hit    = load_match && (match_be == 4'b1111);
  assign fwdValid   = fwd_hit;
  assign fwdData    = fwd_hit ? match_data : 32'h0;
`else
  always_comb begin
    match    = 1'b0;
    scan_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PtrW'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == ALUResultM[31:2])) begin
        match = 1'b1;
      end
    end
  end

  assign load_match = MemReadM && match;
  assign fwd_hit    = 1'b0;
  assign fwdValid   = 1'b0;
  assign fwdData    = 32'h0;
`endif

  // A full buffer stalls a store even if the head pops this cycle
  assign stallM = (store_req && full) || (load_match && !fwd_hit);

  // Memory side is driven straight from the head entry
  assign memReq   = !empty;
  assign memAddr  = memReq ? {addr_q[head_q], 2'b00} : 32'h0;
  assign memWData = memReq ? data_q[head_q] : 32'h0;
  assign memBE    = memReq ? be_q[head_q] : 4'b0000;

  // Next-state for pointers, occupancy and entry storage
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;

    if (pop) begin
      head_d           = head_q + PtrW'(1);
      valid_d[head_q]  = 1'b0;
    end

    if (push) begin
      tail_d           = tail_q + PtrW'(1);
      valid_d[tail_q]  = 1'b1;
      addr_d[tail_q]   = ALUResultM[31:2];
      be_d[tail_q]     = byteEnable;
      data_d[tail_q]   = shifted_data;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously so pending stores are discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload needs no reset; validity lives in valid_q
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    be_q   <= be_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  byteEnable;
  logic        stallM;
  logic        fwdValid;
  logic [31:0] fwdData;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memBE;
  logic        memAck;
  logic        empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .byteEnable (byteEnable),
    .stallM     (stallM),
    .fwdValid   (fwdValid),
    .fwdData    (fwdData),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memBE      (memBE),
    .memAck     (memAck),
    .empty      (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemWriteM  = 1'b0;
    MemReadM   = 1'b0;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    byteEnable = 4'b0000;
    memAck     = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    MemWriteM  = 1'b1;
    ALUResultM = a;
    WriteDataM = d;
    byteEnable = be;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rst_memReq got %0b exp 0", memReq); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b exp 1", empty); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rst_stallM got %0b exp 0", stallM); end
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL rst_fwdValid got %0b exp 0", fwdValid); end
    checks++; if (fwdData !== 32'h0) begin errors++; $display("FAIL rst_fwdData got %h exp 0", fwdData); end
    checks++; if (memBE !== 4'b0000) begin errors++; $display("FAIL rst_memBE got %b exp 0000", memBE); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sb();
    drive_store(32'h103, 32'hAB, 4'b1000);
    memAck = 1'b1;
    #1;
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL sb_stall got %0b exp 0", stallM); end
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL sb_req_early got %0b exp 0", memReq); end
    tick();
    MemWriteM = 1'b0;
    #1;
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL sb_req got %0b exp 1", memReq); end
    checks++; if (memAddr !== 32'h100) begin errors++; $display("FAIL sb_addr got %h exp 00000100", memAddr); end
    checks++; if (memWData !== 32'hAB000000) begin errors++; $display("FAIL sb_wdata got %h exp ab000000", memWData); end
    checks++; if (memBE !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", memBE); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_empty got %0b exp 1", empty); end
    idle();
    tick();
  endtask

  task automatic test_shift();
    drive_store(32'h12, 32'h1234, 4'b1100);
    tick();
    drive_store(32'h21, 32'hCD, 4'b0010);
    tick();
    idle();
    #1;
    checks++; if (memAddr !== 32'h10) begin errors++; $display("FAIL sh_addr got %h exp 00000010", memAddr); end
    checks++; if (memWData !== 32'h12340000) begin errors++; $display("FAIL sh_wdata got %h exp 12340000", memWData); end
    checks++; if (memBE !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", memBE); end
    memAck = 1'b1;
    tick();
    checks++; if (memAddr !== 32'h20) begin errors++; $display("FAIL sb1_addr got %h exp 00000020", memAddr); end
    checks++; if (memWData !== 32'h0000CD00) begin errors++; $display("FAIL sb1_wdata got %h exp 0000cd00", memWData); end
    checks++; if (memBE !== 4'b0010) begin errors++; $display("FAIL sb1_be got %b exp 0010", memBE); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL shift_empty got %0b exp 1", empty); end
    idle();
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h400 + 32'(4 * i), 32'(i + 1), 4'b1111);
      #1;
      checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL full_stall%0d got %0b exp 0", i, stallM); end
      tick();
    end
    drive_store(32'h410, 32'd5, 4'b1111);
    #1;
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL full_stall4 got %0b exp 1", stallM); end
    memAck = 1'b1;
    #1;
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL full_stall_pop got %0b exp 1", stallM); end
    checks++; if (memAddr !== 32'h400) begin errors++; $display("FAIL full_drain0 got %h exp 00000400", memAddr); end
    tick();
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL full_accept got %0b exp 0", stallM); end
    checks++; if (memAddr !== 32'h404) begin errors++; $display("FAIL full_drain1 got %h exp 00000404", memAddr); end
    tick();
    MemWriteM = 1'b0;
    #1;
    checks++; if (memAddr !== 32'h408) begin errors++; $display("FAIL full_drain2 got %h exp 00000408", memAddr); end
    tick();
    checks++; if (memAddr !== 32'h40C) begin errors++; $display("FAIL full_drain3 got %h exp 0000040c", memAddr); end
    tick();
    checks++; if (memAddr !== 32'h410) begin errors++; $display("FAIL full_drain4 got %h exp 00000410", memAddr); end
    checks++; if (memWData !== 32'd5) begin errors++; $display("FAIL full_data4 got %h exp 00000005", memWData); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got %0b exp 1", empty); end
    idle();
    tick();
  endtask

  task automatic test_push_pop();
    drive_store(32'h500, 32'h11, 4'b1111);
    tick();
    idle();
    #1;
    checks++; if (memAddr !== 32'h500) begin errors++; $display("FAIL pp_head0 got %h exp 00000500", memAddr); end
    tick();
    drive_store(32'h504, 32'h22, 4'b1111);
    memAck = 1'b1;
    #1;
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL pp_stall got %0b exp 0", stallM); end
    tick();
    idle();
    #1;
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL pp_req got %0b exp 1", memReq); end
    checks++; if (memAddr !== 32'h504) begin errors++; $display("FAIL pp_head1 got %h exp 00000504", memAddr); end
    checks++; if (memWData !== 32'h22) begin errors++; $display("FAIL pp_data1 got %h exp 00000022", memWData); end
    tick();
    memAck = 1'b1;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty got %0b exp 1", empty); end
    idle();
    tick();
  endtask

  task automatic test_load_match();
    drive_store(32'h202, 32'hBEEF, 4'b1100);
    tick();
    idle();
    MemReadM   = 1'b1;
    ALUResultM = 32'h200;
    #1;
    checks++; if (memWData !== 32'hBEEF0000) begin errors++; $display("FAIL lm_wdata got %h exp beef0000", memWData); end
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL lm_stall got %0b exp 1", stallM); end
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL lm_fwd got %0b exp 0", fwdValid); end
    ALUResultM = 32'h204;
    #1;
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL lm_nomatch got %0b exp 0", stallM); end
    ALUResultM = 32'h200;
    memAck     = 1'b1;
    #1;
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL lm_popmatch got %0b exp 1", stallM); end
    tick();
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL lm_drained got %0b exp 0", stallM); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lm_empty got %0b exp 1", empty); end
    idle();
    tick();
  endtask

  task automatic test_forward();
    drive_store(32'h300, 32'hDEADBEEF, 4'b1111);
    tick();
    idle();
    MemReadM   = 1'b1;
    ALUResultM = 32'h300;
    #1;
`ifdef STB_FORWARD_EN
    checks++; if (fwdValid !== 1'b1) begin errors++; $display("FAIL fw_valid got %0b exp 1", fwdValid); end
    checks++; if (fwdData !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_data got %h exp deadbeef", fwdData); end
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL fw_stall got %0b exp 0", stallM); end
`else
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL fw_valid got %0b exp 0", fwdValid); end
    checks++; if (fwdData !== 32'h0) begin errors++; $display("FAIL fw_data got %h exp 0", fwdData); end
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL fw_stall got %0b exp 1", stallM); end
`endif
    MemReadM = 1'b0;
    #1;
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL fw_noread_v got %0b exp 0", fwdValid); end
    checks++; if (fwdData !== 32'h0) begin errors++; $display("FAIL fw_noread_d got %h exp 0", fwdData); end
    // A younger partial store to the same word must block forwarding
    drive_store(32'h301, 32'h77, 4'b0010);
    tick();
    idle();
    MemReadM   = 1'b1;
    ALUResultM = 32'h300;
    #1;
    checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL fw_young_stall got %0b exp 1", stallM); end
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL fw_young_v got %0b exp 0", fwdValid); end
    MemReadM = 1'b0;
    memAck   = 1'b1;
    tick();
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fw_empty got %0b exp 1", empty); end
    idle();
    tick();
  endtask

  task automatic test_reset_pending();
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h600 + 32'(4 * i), 32'(i + 8), 4'b1111);
      tick();
    end
    idle();
    #1;
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL rp_req_pre got %0b exp 1", memReq); end
    reset  = 1'b1;
    memAck = 1'b1;
    #1;
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rp_req got %0b exp 0", memReq); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rp_empty got %0b exp 1", empty); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rp_ack_empty got %0b exp 1", empty); end
    memAck = 1'b0;
    drive_store(32'h700, 32'h99, 4'b1111);
    tick();
    idle();
    #1;
    checks++; if (memAddr !== 32'h700) begin errors++; $display("FAIL rp_head got %h exp 00000700", memAddr); end
    memAck = 1'b1;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rp_final_empty got %0b exp 1", empty); end
    idle();
  endtask

  initial begin
    test_reset();
    test_sb();
    test_shift();
    test_full();
    test_push_pop();
    test_load_match();
    test_forward();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
